// File: rtl/video_pkg.sv
// -----------------------------------------------------------------------------
// video_pkg
//
// Purpose: definitions shared by the video pixel serialiser.
//   - state_e            : shifter FSM states (IDLE, SHIFT)
//   - pixels_per_word()  : number of pixels carried by one display word
//   - is_pow2()          : power-of-two test used by the parameter checks
//   - params_legal()     : combined legality check for the shifter parameters
// -----------------------------------------------------------------------------
package video_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  function automatic int pixels_per_word(input int data_width, input int bpp);
    return data_width / bpp;
  endfunction

  function automatic bit is_pow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

  // BPP must split the word evenly, the FIFO must be a power of two of at
  // least two entries, and the read latency is limited to 0..2 cycles.
  function automatic bit params_legal(input int data_width, input int bpp,
                                      input int fifo_depth, input int read_latency);
    return (bpp > 0) && (data_width >= bpp) && ((data_width % bpp) == 0) &&
           is_pow2(fifo_depth) && (fifo_depth >= 2) &&
           (read_latency >= 0) && (read_latency <= 2);
  endfunction

endpackage

// File: rtl/pixel_fifo.sv
// -----------------------------------------------------------------------------
// pixel_fifo
//
// Purpose: small synchronous word FIFO feeding the pixel shifter.
//   A pop and a push in the same cycle are both honoured even when the FIFO
//   is full (the popped slot is reused). flush empties the FIFO and wins over
//   any same-cycle push or pop.
//
// Ports:
//   clk      in   system clock
//   reset    in   asynchronous active-high reset (FIFO empty)
//   push     in   write wr_data this cycle
//   pop      in   discard the head word this cycle
//   flush    in   empty the FIFO
//   wr_data  in   WIDTH  word to write
//   rd_data  out  WIDTH  head word (valid when empty=0)
//   empty    out  no words stored
//   full     out  DEPTH words stored
// -----------------------------------------------------------------------------
module pixel_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        do_push;
  logic        do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);

  assign rd_data = mem[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/video_shifter.sv
// -----------------------------------------------------------------------------
// video_shifter
//
// Purpose: serialises display words snooped from memory-bus reads into
//   BPP-bit pixels, MSB first, each held divider+1 clocks. Words are queued
//   in a pixel_fifo; consecutive words are shifted out without a gap while
//   the FIFO has data. A rising edge of blank flushes everything; while
//   blank is high words are still captured for the next line.
//
// Optional feature: define VIDEO_SHIFTER_STATUS_EN to build the sticky
//   underrun/overflow flags and make clearStatus functional. Without it both
//   flags are tied low and clearStatus is ignored.
//
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous active-high reset
//   loadStrobe   in   one-cycle pulse marking a display-memory read
//   dataIn       in   DATA_WIDTH  read data, valid READ_LATENCY after loadStrobe
//   divider      in   DIV_BITS    pixel period = divider+1 clocks
//   blank        in   high during blanking/sync
//   clearStatus  in   clears the sticky flags (wins over a same-cycle set)
//   pixelOut     out  BPP         current pixel, IDLE_PIXEL when not valid
//   pixelValid   out  pixelOut carries display data
//   fifoFull     out  FIFO holds FIFO_DEPTH words
//   underrun     out  sticky: shifter ran dry mid-line
//   overflow     out  sticky: word dropped on full FIFO
// -----------------------------------------------------------------------------
module video_shifter
  import video_pkg::*;
#(
  parameter int             DATA_WIDTH   = 8,
  parameter int             BPP          = 1,
  parameter int             DIV_BITS     = 4,
  parameter int             FIFO_DEPTH   = 2,
  parameter int             READ_LATENCY = 1,
  parameter logic [BPP-1:0] IDLE_PIXEL   = '1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  loadStrobe,
  input  logic [DATA_WIDTH-1:0] dataIn,
  input  logic [DIV_BITS-1:0]   divider,
  input  logic                  blank,
  input  logic                  clearStatus,
  output logic [BPP-1:0]        pixelOut,
  output logic                  pixelValid,
  output logic                  fifoFull,
  output logic                  underrun,
  output logic                  overflow
);

  localparam int PPW = pixels_per_word(DATA_WIDTH, BPP);
  localparam int CW  = $clog2(PPW + 1);

  if (!params_legal(DATA_WIDTH, BPP, FIFO_DEPTH, READ_LATENCY)) begin : g_param_check
    $error("video_shifter: illegal DATA_WIDTH/BPP/FIFO_DEPTH/READ_LATENCY combination");
  end

  // ---------------------------------------------------------------------------
  // Capture: align the strobe with the memory read data.
  // ---------------------------------------------------------------------------
  logic push;

  if (READ_LATENCY == 0) begin : g_no_delay
    assign push = loadStrobe;
  end else begin : g_delay
    logic [READ_LATENCY-1:0] strobe_q, strobe_d;

    always_comb begin
      strobe_d = (strobe_q << 1) | READ_LATENCY'(loadStrobe);
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) strobe_q <= '0;
      else       strobe_q <= strobe_d;
    end

    assign push = strobe_q[READ_LATENCY-1];
  end

  // ---------------------------------------------------------------------------
  // Blank edge detect. Reset value 1 so a line that starts in blank does not
  // look like a fresh rising edge.
  // ---------------------------------------------------------------------------
  logic blank_q, blank_d;
  logic blank_rise;

  assign blank_d    = blank;
  assign blank_rise = blank && !blank_q;

  // ---------------------------------------------------------------------------
  // Word FIFO
  // ---------------------------------------------------------------------------
  logic                  fifo_pop;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic [DATA_WIDTH-1:0] fifo_rd_data;

  pixel_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (fifo_pop),
    .flush   (blank_rise),
    .wr_data (dataIn),
    .rd_data (fifo_rd_data),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  // ---------------------------------------------------------------------------
  // Shifter FSM: state register
  // ---------------------------------------------------------------------------
  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DIV_BITS-1:0]   phase_q, phase_d;
  logic [DIV_BITS-1:0]   div_q, div_d;
  logic                  underrun_set;
  logic                  overflow_set;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      count_q <= '0;
      phase_q <= '0;
      div_q   <= '0;
      blank_q <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      count_q <= count_d;
      phase_q <= phase_d;
      div_q   <= div_d;
      blank_q <= blank_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Shifter FSM: next state and datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    count_d      = count_q;
    phase_d      = phase_q;
    div_d        = div_q;
    fifo_pop     = 1'b0;
    underrun_set = 1'b0;

    if (blank_rise) begin
      // Flush wins over everything, including an end-of-word tick.
      state_d = IDLE;
      shift_d = '0;
      count_d = '0;
      phase_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!blank && !fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_rd_data;
            count_d  = CW'(PPW);
            phase_d  = '0;
            div_d    = divider;
            state_d  = SHIFT;
          end
        end

        SHIFT: begin
          if (phase_q == div_q) begin
            // Tick: the divider is resampled so a new rate starts cleanly
            // on the next pixel.
            phase_d = '0;
            div_d   = divider;
            if (count_q > CW'(1)) begin
              shift_d = shift_q << BPP;
              count_d = count_q - CW'(1);
            end else if (!fifo_empty) begin
              fifo_pop = 1'b1;
              shift_d  = fifo_rd_data;
              count_d  = CW'(PPW);
            end else begin
              state_d      = IDLE;
              count_d      = '0;
              underrun_set = 1'b1;
            end
          end else begin
            phase_d = phase_q + DIV_BITS'(1);
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  // A push onto a full FIFO is lost unless the shifter frees a slot in the
  // same cycle; a push coincident with a flush is discarded without a flag.
  assign overflow_set = push && fifo_full && !fifo_pop && !blank_rise;

  // ---------------------------------------------------------------------------
  // Shifter FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    pixelValid = (state_q == SHIFT);
    pixelOut   = IDLE_PIXEL;
    if (state_q == SHIFT) pixelOut = shift_q[DATA_WIDTH-1 -: BPP];
  end

  assign fifoFull = fifo_full;

  // ---------------------------------------------------------------------------
  // Sticky status flags
  // ---------------------------------------------------------------------------
`ifdef VIDEO_SHIFTER_STATUS_EN
  logic underrun_q, underrun_d;
  logic overflow_q, overflow_d;

  always_comb begin
    underrun_d = clearStatus ? 1'b0 : (underrun_q | underrun_set);
    overflow_d = clearStatus ? 1'b0 : (overflow_q | overflow_set);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      underrun_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      underrun_q <= underrun_d;
      overflow_q <= overflow_d;
    end
  end

  assign underrun = underrun_q;
  assign overflow = overflow_q;
`else
  logic unused_status;
  assign unused_status = ^{clearStatus, underrun_set, overflow_set};

  assign underrun = 1'b0;
  assign overflow = 1'b0;
`endif

endmodule
